// File: rtl/change_dispense_ctrl_pkg.sv
// Shared constants and types for the change dispense controller.
// Change codes are expressed in 5c units, so a code doubles as the amount owed.
package change_dispense_ctrl_pkg;

  localparam logic [2:0] CODE_NONE   = 3'b000;
  localparam logic [2:0] NICKEL      = 3'b001;
  localparam logic [2:0] DIME        = 3'b010;
  localparam logic [2:0] NICKEL_DIME = 3'b011;
  localparam logic [2:0] DIME_DIME   = 3'b100;

  // Value of one coin in 5c units.
  localparam logic [2:0] UNITS_NICKEL = 3'd1;
  localparam logic [2:0] UNITS_DIME   = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAN     = 3'd1,
    S_PULSE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  // Codes above DIME_DIME are not a payable amount.
  function automatic logic code_is_payable(input logic [2:0] code);
    return (code <= DIME_DIME);
  endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Bus between the vending side / hoppers and the change dispense controller.
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; req_code must be stable while req_valid is high.
// done is a single-cycle pulse, and err/short_units are only meaningful with it.
interface change_dispense_ctrl_if #(
  parameter int INV_W = 8
);
  import change_dispense_ctrl_pkg::*;

  logic             req_valid;
  logic [2:0]       req_code;
  logic             req_ready;
  logic             disp_nickel;
  logic             disp_dime;
  logic             hop_ack;
  logic             refill_valid;
  logic [INV_W-1:0] refill_nickels;
  logic [INV_W-1:0] refill_dimes;
  logic             done;
  logic             err;
  logic [2:0]       short_units;
  logic [INV_W-1:0] nickel_cnt;
  logic [INV_W-1:0] dime_cnt;
  state_t           dbg_state;

  // Requester / hopper side.
  modport master (
    output req_valid, req_code, hop_ack, refill_valid, refill_nickels, refill_dimes,
    input  req_ready, disp_nickel, disp_dime, done, err, short_units,
           nickel_cnt, dime_cnt, dbg_state
  );

  // Controller side.
  modport slave (
    input  req_valid, req_code, hop_ack, refill_valid, refill_nickels, refill_dimes,
    output req_ready, disp_nickel, disp_dime, done, err, short_units,
           nickel_cnt, dime_cnt, dbg_state
  );

endinterface

// File: rtl/change_dispense_ctrl_inventory.sv
// coin_inventory: coin stock counter with saturating refill and single-coin
// decrement. A refill and a decrement in the same cycle net out before
// saturation, so cnt + refill - 1 is clamped only once.
module coin_inventory #(
  parameter int INV_W = 8,
  parameter int INIT  = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             add_en_i,
  input  logic [INV_W-1:0] add_i,
  input  logic             dec_i,
  output logic [INV_W-1:0] cnt_o
);

  logic [INV_W-1:0] cnt_q;
  logic [INV_W-1:0] cnt_d;
  logic [INV_W:0]   add_ext;
  logic             dec_ok;
  logic [INV_W:0]   sum;

  // Next count: add refill, remove one coin if any stock exists, clamp at max.
  always_comb begin
    add_ext = add_en_i ? {1'b0, add_i} : '0;
    dec_ok  = dec_i && ((cnt_q != '0) || (add_ext != '0));
    sum     = {1'b0, cnt_q} + add_ext - {{INV_W{1'b0}}, dec_ok};
    cnt_d   = sum[INV_W] ? {INV_W{1'b1}} : sum[INV_W-1:0];
  end

  // Stock register, reloaded to its initial fill on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= INV_W'(INIT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl: pays out change one coin at a time through the dime
// and nickel hoppers, preferring dimes and falling back to nickels, and
// reports any unpaid remainder with the completion pulse.
// Build option: define CHG_TIMEOUT_EN to fault a payout whose hopper never
// acknowledges within TIMEOUT_CYC cycles; without it WAIT_ACK waits forever.
module change_dispense_ctrl
  import change_dispense_ctrl_pkg::*;
#(
  parameter int INV_W       = 8,
  parameter int NICKEL_INIT = 20,
  parameter int DIME_INIT   = 20,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                    clock,
  input logic                    reset,
  change_dispense_ctrl_if.slave  bus
);

  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  state_t           state_q;
  logic             req_ready_q;
  logic             disp_nickel_q;
  logic             disp_dime_q;
  logic             done_q;
  logic             err_q;
  logic [2:0]       short_q;
  logic [2:0]       rem_q;
  logic             sel_dime_q;
  logic [PW-1:0]    pulse_cnt_q;
  logic [INV_W-1:0] nickel_cnt;
  logic [INV_W-1:0] dime_cnt;
  logic             ack_taken;
  logic             dec_nickel;
  logic             dec_dime;

`ifdef CHG_TIMEOUT_EN
  logic [7:0]       wait_cnt_q;
`else
  logic             unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT_CYC));
`endif

  // A hopper ack only counts while the controller is waiting for one.
  assign ack_taken  = (state_q == S_WAIT_ACK) && bus.hop_ack;
  assign dec_dime   = ack_taken && sel_dime_q;
  assign dec_nickel = ack_taken && !sel_dime_q;

  coin_inventory #(.INV_W(INV_W), .INIT(NICKEL_INIT)) u_nickel_inv (
    .clk_i    (clock),
    .rst_i    (reset),
    .add_en_i (bus.refill_valid),
    .add_i    (bus.refill_nickels),
    .dec_i    (dec_nickel),
    .cnt_o    (nickel_cnt)
  );

  coin_inventory #(.INV_W(INV_W), .INIT(DIME_INIT)) u_dime_inv (
    .clk_i    (clock),
    .rst_i    (reset),
    .add_en_i (bus.refill_valid),
    .add_i    (bus.refill_dimes),
    .dec_i    (dec_dime),
    .cnt_o    (dime_cnt)
  );

  // Payout sequencer; every output is registered and set on the transition
  // into the state it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      disp_nickel_q <= 1'b0;
      disp_dime_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      short_q       <= 3'd0;
      rem_q         <= 3'd0;
      sel_dime_q    <= 1'b0;
      pulse_cnt_q   <= '0;
`ifdef CHG_TIMEOUT_EN
      wait_cnt_q    <= 8'd0;
`endif
    end else begin
      // Completion outputs live for exactly one cycle.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      short_q <= 3'd0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (bus.req_code == CODE_NONE) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (!code_is_payable(bus.req_code)) begin
              state_q <= S_FAULT;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              rem_q   <= bus.req_code;
              state_q <= S_PLAN;
            end
          end
        end
        S_PLAN: begin
          if (rem_q == 3'd0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if ((rem_q >= UNITS_DIME) && (dime_cnt != '0)) begin
            sel_dime_q  <= 1'b1;
            disp_dime_q <= 1'b1;
            pulse_cnt_q <= PW'(PULSE_CYC - 1);
            state_q     <= S_PULSE;
          end else if (nickel_cnt != '0) begin
            sel_dime_q    <= 1'b0;
            disp_nickel_q <= 1'b1;
            pulse_cnt_q   <= PW'(PULSE_CYC - 1);
            state_q       <= S_PULSE;
          end else begin
            state_q <= S_FAULT;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            short_q <= rem_q;
          end
        end
        S_PULSE: begin
          if (pulse_cnt_q == '0) begin
            disp_nickel_q <= 1'b0;
            disp_dime_q   <= 1'b0;
            state_q       <= S_WAIT_ACK;
`ifdef CHG_TIMEOUT_EN
            wait_cnt_q    <= 8'd0;
`endif
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (bus.hop_ack) begin
            rem_q   <= rem_q - (sel_dime_q ? UNITS_DIME : UNITS_NICKEL);
            state_q <= S_PLAN;
          end
`ifdef CHG_TIMEOUT_EN
          else if (wait_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
            state_q <= S_FAULT;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            short_q <= rem_q;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        S_DONE, S_FAULT: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q       <= S_IDLE;
          req_ready_q   <= 1'b1;
          disp_nickel_q <= 1'b0;
          disp_dime_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.disp_nickel = disp_nickel_q;
  assign bus.disp_dime   = disp_dime_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.short_units = short_q;
  assign bus.nickel_cnt  = nickel_cnt;
  assign bus.dime_cnt    = dime_cnt;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: payouts with and without stock,
// nickel substitution, shortfall, refill arithmetic, bad/zero codes, ack
// withholding and reset mid-payout.
module tb_change_dispense_ctrl;
  import change_dispense_ctrl_pkg::*;

  localparam int INV_W       = 8;
  localparam int PULSE_CYC   = 4;
  localparam int TIMEOUT_CYC = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   strobes;
  int   n;
  int   seen;

  change_dispense_ctrl_if #(.INV_W(INV_W)) bus ();

  change_dispense_ctrl #(
    .INV_W       (INV_W),
    .NICKEL_INIT (20),
    .DIME_INIT   (20),
    .PULSE_CYC   (PULSE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_req(input logic [2:0] code);
    bus.req_valid = 1'b1;
    bus.req_code  = code;
    step();
    bus.req_valid = 1'b0;
    bus.req_code  = 3'd0;
  endtask

  task automatic do_ack();
    bus.hop_ack = 1'b1;
    step();
    bus.hop_ack = 1'b0;
  endtask

  task automatic refill(input logic [INV_W-1:0] nick, input logic [INV_W-1:0] dime);
    bus.refill_valid   = 1'b1;
    bus.refill_nickels = nick;
    bus.refill_dimes   = dime;
    step();
    bus.refill_valid   = 1'b0;
    bus.refill_nickels = '0;
    bus.refill_dimes   = '0;
  endtask

  // Wait for one strobe, measure it, and leave the DUT in WAIT_ACK.
  task automatic wait_strobe(input string tag, input logic exp_dime);
    int w = 0;
    int len = 0;
    logic saw_dime = 1'b0;
    logic both = 1'b0;
    while (!(bus.disp_nickel || bus.disp_dime) && w < 50) begin
      step();
      w++;
    end
    check({tag, "_start"}, 32'(w < 50), 1);
    saw_dime = bus.disp_dime;
    while ((bus.disp_nickel || bus.disp_dime) && len < 20) begin
      if (bus.disp_nickel && bus.disp_dime) both = 1'b1;
      len++;
      step();
    end
    check({tag, "_len"}, len, PULSE_CYC);
    check({tag, "_sel"}, 32'(saw_dime), 32'(exp_dime));
    check({tag, "_both"}, 32'(both), 0);
  endtask

  // Pay one coin without detailed checks (used to drain stock).
  task automatic drain_coin();
    int w = 0;
    while (!(bus.disp_nickel || bus.disp_dime) && w < 50) begin
      step();
      w++;
    end
    check("drain_start", 32'(w < 50), 1);
    w = 0;
    while ((bus.disp_nickel || bus.disp_dime) && w < 20) begin
      step();
      w++;
    end
    do_ack();
  endtask

  task automatic wait_done(input string tag, input logic exp_err, input logic [2:0] exp_short,
                           output int lat_o, output int strobes_o);
    lat_o = 0;
    strobes_o = 0;
    while (!bus.done && lat_o < 400) begin
      if (bus.disp_nickel || bus.disp_dime) strobes_o++;
      step();
      lat_o++;
    end
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "_short"}, 32'(bus.short_units), 32'(exp_short));
    step();
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
    check({tag, "_ready"}, 32'(bus.req_ready), 1);
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_code       = 3'd0;
    bus.hop_ack        = 1'b0;
    bus.refill_valid   = 1'b0;
    bus.refill_nickels = '0;
    bus.refill_dimes   = '0;
    repeat (3) step();

    // Reset state
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_short", 32'(bus.short_units), 0);
    check("rst_strobes", 32'({bus.disp_nickel, bus.disp_dime}), 0);
    check("rst_nickels", 32'(bus.nickel_cnt), 20);
    check("rst_dimes", 32'(bus.dime_cnt), 20);
    rst = 1'b0;
    step();

    // 15c with stock: dime then nickel, done two cycles after the last ack
    send_req(NICKEL_DIME);
    wait_strobe("t1_c1", 1'b1);
    do_ack();
    wait_strobe("t1_c2", 1'b0);
    do_ack();
    wait_done("t1", 1'b0, 3'd0, lat, strobes);
    check("t1_latency", lat, 1);
    check("t1_dimes", 32'(bus.dime_cnt), 19);
    check("t1_nickels", 32'(bus.nickel_cnt), 19);

    // Drain all 19 dimes
    for (int i = 0; i < 9; i++) begin
      send_req(DIME_DIME);
      drain_coin();
      drain_coin();
      wait_done("drain_d", 1'b0, 3'd0, lat, strobes);
    end
    send_req(DIME);
    drain_coin();
    wait_done("drain_d1", 1'b0, 3'd0, lat, strobes);
    check("t2_dimes_empty", 32'(bus.dime_cnt), 0);

    // 20c with no dimes: four nickels
    send_req(DIME_DIME);
    for (int i = 0; i < 4; i++) begin
      wait_strobe("t2_coin", 1'b0);
      do_ack();
    end
    wait_done("t2", 1'b0, 3'd0, lat, strobes);
    check("t2_nickels", 32'(bus.nickel_cnt), 15);

    // Drain the remaining nickels, then stock a single dime
    for (int i = 0; i < 15; i++) begin
      send_req(NICKEL);
      drain_coin();
      wait_done("drain_n", 1'b0, 3'd0, lat, strobes);
    end
    check("t3_nickels_empty", 32'(bus.nickel_cnt), 0);
    refill(8'd0, 8'd1);
    check("t3_dime_refill", 32'(bus.dime_cnt), 1);

    // 15c with one dime and no nickels: shortfall of one unit
    send_req(NICKEL_DIME);
    wait_strobe("t3_c1", 1'b1);
    do_ack();
    wait_done("t3", 1'b1, 3'd1, lat, strobes);
    check("t3_dimes", 32'(bus.dime_cnt), 0);

    // Refill coincident with a dime ack: 2 + 5 - 1
    refill(8'd0, 8'd2);
    check("t4_dimes_pre", 32'(bus.dime_cnt), 2);
    send_req(DIME);
    wait_strobe("t4_c1", 1'b1);
    bus.hop_ack        = 1'b1;
    bus.refill_valid   = 1'b1;
    bus.refill_dimes   = 8'd5;
    step();
    bus.hop_ack        = 1'b0;
    bus.refill_valid   = 1'b0;
    bus.refill_dimes   = 8'd0;
    check("t4_dimes_merge", 32'(bus.dime_cnt), 6);
    wait_done("t4", 1'b0, 3'd0, lat, strobes);

    // Saturating refill
    refill(8'd250, 8'd0);
    check("t4_nickels_250", 32'(bus.nickel_cnt), 250);
    refill(8'd10, 8'd0);
    check("t4_nickels_sat", 32'(bus.nickel_cnt), 255);

    // Bad code and zero code; stray ack while idle
    send_req(3'b110);
    wait_done("t5_bad", 1'b1, 3'd0, lat, strobes);
    check("t5_bad_strobes", strobes, 0);
    send_req(CODE_NONE);
    wait_done("t5_zero", 1'b0, 3'd0, lat, strobes);
    check("t5_zero_strobes", strobes, 0);
    do_ack();
    check("t5_idle_ack_dimes", 32'(bus.dime_cnt), 6);
    check("t5_idle_ack_nickels", 32'(bus.nickel_cnt), 255);

    // Withheld ack on a 10c request
    send_req(DIME);
    wait_strobe("t6_c1", 1'b1);
`ifdef CHG_TIMEOUT_EN
    wait_done("t6_timeout", 1'b1, 3'd2, lat, strobes);
    check("t6_timeout_lat", lat, TIMEOUT_CYC);
    check("t6_timeout_dimes", 32'(bus.dime_cnt), 6);
`else
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.done) seen++;
      step();
    end
    check("t6_no_done_waiting", seen, 0);
    check("t6_dimes_waiting", 32'(bus.dime_cnt), 6);
    do_ack();
    wait_done("t6_late_ack", 1'b0, 3'd0, lat, strobes);
    check("t6_late_ack_lat", lat, 1);
    check("t6_dimes_after", 32'(bus.dime_cnt), 5);
`endif

    // Reset during PULSE abandons the payout
    send_req(DIME);
    n = 0;
    while (!bus.disp_dime && n < 20) begin
      step();
      n++;
    end
    check("t6_rst_strobe_seen", 32'(n < 20), 1);
    rst = 1'b1;
    step();
    check("t6_rst_strobe_drop", 32'({bus.disp_nickel, bus.disp_dime}), 0);
    check("t6_rst_no_done", 32'(bus.done), 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done || bus.disp_dime || bus.disp_nickel) seen++;
      step();
    end
    check("t6_rst_quiet", seen, 0);
    check("t6_rst_ready", 32'(bus.req_ready), 1);
    check("t6_rst_dimes", 32'(bus.dime_cnt), 20);
    check("t6_rst_nickels", 32'(bus.nickel_cnt), 20);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
